stdc_readout_sched: RTL
=======================

// Module: stdc_readout_sched
// PURPOSE
// Hardware readout sequencer for the STDC timestamp FIFO, replacing CPU polling of STATUS/TDC_DATA/CTRL.
// Pops timestamps, filters them by edge polarity, and packs accepted ones into message-queue slots:
// one header word plus up to G_MAX_TS timestamp words. A slot is flushed on fill, on timeout, or on disable.
// Sits between the STDC core FIFO port and one outgoing mqueue slot in the WR node fabric.
// PARAMETERS
// G_MAX_TS      16   maximum timestamp words per packet (1..255)
// G_ADDR_W      8    mqueue slot word-address width; must satisfy G_MAX_TS+1 <= 2**G_ADDR_W
// G_TMO_W       16   width of the timeout counter/config
// PORTS
// clk_sys_i       in   1         system clock; all logic on its rising edge
// rst_sys_i       in   1         synchronous active-high reset
// enable_i        in   1         readout enable
// edge_mask_i     in   2         bit0: accept rising (ts[31]=1); bit1: accept falling (ts[31]=0)
// timeout_i       in   G_TMO_W   cycles from packet open until flush when FIFO is empty
// fifo_empty_i    in   1         STDC FIFO empty flag
// fifo_rd_o       out  1         one-cycle pop strobe; data valid on fifo_data_i the following cycle
// fifo_data_i     in   32        [31] polarity, [30:3] 125 MHz cycles, [2:0] fine phase
// mq_claim_o      out  1         slot claim request; held high until mq_ready_i
// mq_ready_i      in   1         slot granted
// mq_we_o         out  1         slot word write strobe
// mq_addr_o       out  G_ADDR_W  slot word address
// mq_data_o       out  32        slot write data
// mq_commit_o     out  1         one-cycle packet commit strobe
// busy_o          out  1         high in every state except IDLE
// seq_o           out  16        sequence number of the next packet
// rejected_o      out  16        saturating count of filtered-out timestamps
// BEHAVIOUR
// - Reset: every output 0, FSM in IDLE, seq=0, rejected=0, count=0, open=0.
// - States: IDLE, POP, CAP, CLAIM, WRITE, WAIT, HDR, COMMIT.
// - IDLE: if enable_i && !fifo_empty_i -> POP.
// - POP: fifo_rd_o=1 for exactly one cycle -> CAP.
// - CAP: sample fifo_data_i. Accept = edge_mask_i[~ts[31]] (rising uses bit0, falling uses bit1).
//   - Rejected: rejected++ (saturating at 0xFFFF); go to WAIT if open, else IDLE.
//   - Accepted, not open: latch ts into hold register, set open, clear tmo counter -> CLAIM.
//   - Accepted, open: -> WRITE.
// - CLAIM: mq_claim_o=1 until mq_ready_i is sampled high -> WRITE. No timeout while waiting for the slot.
// - WRITE: one-cycle mq_we_o, addr=1+count, data=ts; count++.
//   - If count reaches G_MAX_TS -> HDR; else -> WAIT.
// - WAIT (open only):
//   - If !enable_i -> HDR.
//   - Else if !fifo_empty_i -> POP.
//   - Else if tmo >= timeout_i -> HDR.
//   - Else stay. Fill takes priority over timeout when both occur.
// - tmo counter: increments every cycle while open (saturating); cleared on packet open.
//   With timeout_i=0, flush happens on the first WAIT cycle with the FIFO empty.
// - HDR: one-cycle mq_we_o, addr=0, data={seq[15:0], 8'h00, count[7:0]} -> COMMIT.
// - COMMIT: mq_commit_o=1 for one cycle; seq++ (wraps 0xFFFF->0); count=0; open=0 -> IDLE.
// - No empty packet is ever claimed or committed. count>=1 at HDR.
// - enable_i low in IDLE blocks new pops. Low mid-packet: an in-flight POP/CAP/CLAIM/WRITE completes,
//   then the packet flushes. FIFO contents are left untouched.
// - edge_mask_i=0: every popped entry is rejected and counted, so the FIFO drains with no output.
// - rst_sys_i mid-packet abandons the claimed slot without commit; the mqueue owner reclaims it.
// - Throughput: 3 cycles per accepted timestamp (POP, CAP, WRITE), plus 1 for WAIT when looping.
// TESTING
// 1. mask=01, push ts 0x8000_0011 then 0x0000_0022, timeout=10 -> one packet: hdr 0x0000_0001, word1=0x8000_0011; rejected=1.
// 2. mask=11, 20 back-to-back ts, G_MAX_TS=16 -> packet seq0 count16 (hdr 0x0000_0010), packet seq1 count4 after timeout.
// 3. mq_ready_i held low 50 cycles after claim -> claim held, no fifo_rd_o and no writes until grant; data intact.
// 4. enable_i dropped after 3 accepted ts, FIFO non-empty -> packet committed with count 3; no further pops.
// 5. timeout_i=0, single ts -> commit within 6 cycles of fifo_empty_i going low (plus grant latency).
// 6. Reset asserted in WAIT with count=5 -> all outputs 0 next cycle, no commit, seq=0.

Source files
------------

// File: rtl/stdc_readout_sched_if.sv
`default_nettype none
// =============================================================================
// Module : stdc_readout_sched_if
// Desc   : STDC FIFO pop port and mqueue slot write port of the readout sequencer
// Rev    : 1.0
// =============================================================================
interface stdc_readout_sched_if #(
  parameter int G_ADDR_W = 8
);
  logic                fifo_empty_i;
  logic                fifo_rd_o;
  logic [31:0]         fifo_data_i;
  logic                mq_claim_o;
  logic                mq_ready_i;
  logic                mq_we_o;
  logic [G_ADDR_W-1:0] mq_addr_o;
  logic [31:0]         mq_data_o;
  logic                mq_commit_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, mq_ready_i,
    output fifo_rd_o, mq_claim_o, mq_we_o, mq_addr_o, mq_data_o, mq_commit_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, mq_ready_i,
    input  fifo_rd_o, mq_claim_o, mq_we_o, mq_addr_o, mq_data_o, mq_commit_o
  );
endinterface
`default_nettype wire

// File: rtl/stdc_readout_sched.sv
`default_nettype none
// =============================================================================
// Module : stdc_readout_sched
// Desc   : pops STDC timestamps, filters by polarity, packs them into mqueue slots
// Rev    : 1.0
// =============================================================================
module stdc_readout_sched #(
  parameter int G_MAX_TS = 16,
  parameter int G_ADDR_W = 8,
  parameter int G_TMO_W  = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic                 enable_i,
  input  logic [1:0]           edge_mask_i,
  input  logic [G_TMO_W-1:0]   timeout_i,
  stdc_readout_sched_if.master bus,
  output logic                 busy_o,
  output logic [15:0]          seq_o,
  output logic [15:0]          rejected_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_CAP    = 3'd2,
    ST_CLAIM  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_HDR    = 3'd6,
    ST_COMMIT = 3'd7
  } state_t;

  state_t              state_q;
  logic                fifo_rd_q;
  logic                claim_q;
  logic                we_q;
  logic                commit_q;
  logic [G_ADDR_W-1:0] addr_q;
  logic [31:0]         data_q;
  logic [31:0]         hold_q;
  logic [7:0]          count_q;
  logic                open_q;
  logic [G_TMO_W-1:0]  tmo_q;
  logic [15:0]         seq_q;
  logic [15:0]         rej_q;

  logic                accept_d;
  logic [7:0]          count_inc_d;
  logic                full_d;
  logic                flush_d;
  logic [G_ADDR_W-1:0] word_addr_d;

  // Polarity bit 1 is a rising edge and is gated by mask bit 0.
  assign accept_d    = bus.fifo_data_i[31] ? edge_mask_i[0] : edge_mask_i[1];
  assign count_inc_d = count_q + 8'd1;
  assign full_d      = ({1'b0, count_q} + 9'd1) == 9'(G_MAX_TS);
  assign word_addr_d = G_ADDR_W'(count_q) + G_ADDR_W'(1);
  // An empty FIFO lets the timeout flush; a queued entry always wins over it.
  assign flush_d     = !enable_i || (bus.fifo_empty_i && (tmo_q >= timeout_i));

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q  <= ST_IDLE;
      fifo_rd_q <= 1'b0;
      claim_q  <= 1'b0;
      we_q     <= 1'b0;
      commit_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hold_q   <= '0;
      count_q  <= '0;
      open_q   <= 1'b0;
      tmo_q    <= '0;
      seq_q    <= '0;
      rej_q    <= '0;
    end else begin
      fifo_rd_q <= 1'b0;
      we_q      <= 1'b0;
      commit_q  <= 1'b0;
      if (open_q && (tmo_q != '1)) tmo_q <= tmo_q + G_TMO_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (enable_i && !bus.fifo_empty_i) begin
            state_q   <= ST_POP;
            fifo_rd_q <= 1'b1;
          end
        end
        ST_POP: state_q <= ST_CAP;
        ST_CAP: begin
          if (!accept_d) begin
            if (rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
            state_q <= open_q ? ST_WAIT : ST_IDLE;
          end else if (!open_q) begin
            hold_q  <= bus.fifo_data_i;
            open_q  <= 1'b1;
            tmo_q   <= '0;
            claim_q <= 1'b1;
            state_q <= ST_CLAIM;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= word_addr_d;
            data_q  <= bus.fifo_data_i;
            state_q <= ST_WRITE;
          end
        end
        ST_CLAIM: begin
          if (bus.mq_ready_i) begin
            claim_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= word_addr_d;
            data_q  <= hold_q;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          count_q <= count_inc_d;
          if (full_d) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= {seq_q, 8'h00, count_inc_d};
            state_q <= ST_HDR;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_d) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= {seq_q, 8'h00, count_q};
            state_q <= ST_HDR;
          end else if (!bus.fifo_empty_i) begin
            fifo_rd_q <= 1'b1;
            state_q   <= ST_POP;
          end
        end
        ST_HDR: begin
          commit_q <= 1'b1;
          state_q  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          seq_q   <= seq_q + 16'd1;
          count_q <= '0;
          open_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_o   = fifo_rd_q;
  assign bus.mq_claim_o  = claim_q;
  assign bus.mq_we_o     = we_q;
  assign bus.mq_addr_o   = addr_q;
  assign bus.mq_data_o   = data_q;
  assign bus.mq_commit_o = commit_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign seq_o           = seq_q;
  assign rejected_o      = rej_q;

endmodule
`default_nettype wire
